// File: rtl/maq_h_if.sv
// Bundles the hours-stage controls and display outputs of the digital clock.
// The slave modport is the hours stage; the master is whoever drives it.
interface maq_h_if;
  logic       maqh_enable;
  logic       maqh_incremento;
  logic       maqh_ajuste_up;
  logic       maqh_ajuste_down;
  logic       maqh_modo12;
  logic [3:0] maqh_Lsd;
  logic [1:0] maqh_Msd;
  logic       maqh_pm;
  logic       maqh_incrementadia;

  modport slave (
    input  maqh_enable, maqh_incremento, maqh_ajuste_up, maqh_ajuste_down, maqh_modo12,
    output maqh_Lsd, maqh_Msd, maqh_pm, maqh_incrementadia
  );

  modport master (
    output maqh_enable, maqh_incremento, maqh_ajuste_up, maqh_ajuste_down, maqh_modo12,
    input  maqh_Lsd, maqh_Msd, maqh_pm, maqh_incrementadia
  );
endinterface

// File: rtl/maq_h.sv
// Hours stage of the digital clock: keeps hour 0..23, advances on the minutes carry,
// and takes edge-detected up/down button adjustments. Shows BCD digits in 24h or 12h form.
module maq_h #(
  parameter logic [4:0] RESET_HOUR = 5'd0
) (
  input  logic  maqh_clock,
  input  logic  maqh_reset,
  maq_h_if.slave bus
);

  logic [4:0] hora_reg;
  logic       up_prev;
  logic       down_prev;
  logic       up_edge;
  logic       down_edge;
  logic [4:0] hora_inc;
  logic [4:0] hora_dec;
  logic [4:0] hora_next;

  assign up_edge   = bus.maqh_ajuste_up & ~up_prev;
  assign down_edge = bus.maqh_ajuste_down & ~down_prev;

  // Out-of-range hours (24..31) fold back to 0 going up and to 23 going down.
  assign hora_inc = (hora_reg >= 5'd23) ? 5'd0 : hora_reg + 5'd1;
  assign hora_dec = ((hora_reg == 5'd0) || (hora_reg > 5'd23)) ? 5'd23 : hora_reg - 5'd1;

  // Buttons outrank the minutes carry; a carry arriving alongside an adjust is dropped.
  always_comb begin
    hora_next = hora_reg;
    if (up_edge && down_edge)
      hora_next = hora_reg;
    else if (up_edge)
      hora_next = hora_inc;
    else if (down_edge)
      hora_next = hora_dec;
    else if (bus.maqh_enable && bus.maqh_incremento)
      hora_next = hora_inc;
  end

  always_ff @(posedge maqh_clock) begin
    if (!maqh_reset) begin
      hora_reg  <= RESET_HOUR;
      up_prev   <= 1'b0;
      down_prev <= 1'b0;
    end else begin
      hora_reg  <= hora_next;
      up_prev   <= bus.maqh_ajuste_up;
      down_prev <= bus.maqh_ajuste_down;
    end
  end

  logic [4:0] disp;
  logic       pm;

  always_comb begin
    disp = hora_reg;
    pm   = 1'b0;
    if (bus.maqh_modo12) begin
      if (hora_reg == 5'd0) begin
        disp = 5'd12;
      end else if (hora_reg < 5'd12) begin
        disp = hora_reg;
      end else if (hora_reg == 5'd12) begin
        disp = 5'd12;
        pm   = 1'b1;
      end else begin
        disp = hora_reg - 5'd12;
        pm   = 1'b1;
      end
    end
  end

  // Units digit only needs the low nibble: subtracting 20 or 10 mod 16 is exact here.
  always_comb begin
    bus.maqh_Msd = 2'd0;
    bus.maqh_Lsd = disp[3:0];
    if (disp >= 5'd20) begin
      bus.maqh_Msd = 2'd2;
      bus.maqh_Lsd = disp[3:0] - 4'd4;
    end else if (disp >= 5'd10) begin
      bus.maqh_Msd = 2'd1;
      bus.maqh_Lsd = disp[3:0] - 4'd10;
    end
  end

  assign bus.maqh_pm            = pm;
  assign bus.maqh_incrementadia = (hora_reg == 5'd23);

endmodule

// File: tb/tb_maq_h.sv
// Bench for the hours stage: a reference hour model pushes expected display words
// into a queue on every driven cycle; they are popped and checked after the clock edge.
module tb_maq_h;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  maq_h_if bus ();

  maq_h #(.RESET_HOUR(5'd0)) dut (
    .maqh_clock (clk),
    .maqh_reset (rst_n),
    .bus        (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] expq[$];
  int   m_hour      = 0;
  logic m_up_prev   = 1'b0;
  logic m_down_prev = 1'b0;
  logic m_modo12    = 1'b0;

  // Expected {Msd, Lsd, pm, incrementadia} for an hour shown in the given mode.
  function automatic logic [7:0] disp_word(input int h, input logic m12);
    int   d;
    logic p;
    if (!m12) begin
      d = h;
      p = 1'b0;
    end else begin
      p = (h >= 12);
      d = h % 12;
      if (d == 0) d = 12;
    end
    return {2'(d / 10), 4'(d % 10), p, (h == 23)};
  endfunction

  task automatic compare(input string tag, input logic [7:0] expected);
    logic [7:0] observed;
    observed = {bus.maqh_Msd, bus.maqh_Lsd, bus.maqh_pm, bus.maqh_incrementadia};
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h (Msd,Lsd,pm,dia)", tag, observed, expected);
    end
  endtask

  task automatic step(input logic rst, input logic en, input logic inc,
                      input logic up, input logic dn, input logic m12);
    logic ue;
    logic de;
    rst_n                = rst;
    bus.maqh_enable      = en;
    bus.maqh_incremento  = inc;
    bus.maqh_ajuste_up   = up;
    bus.maqh_ajuste_down = dn;
    bus.maqh_modo12      = m12;
    m_modo12             = m12;
    if (!rst) begin
      m_hour      = 0;
      m_up_prev   = 1'b0;
      m_down_prev = 1'b0;
    end else begin
      ue = up & ~m_up_prev;
      de = dn & ~m_down_prev;
      if (ue && de)      m_hour = m_hour;
      else if (ue)       m_hour = (m_hour + 1) % 24;
      else if (de)       m_hour = (m_hour + 23) % 24;
      else if (en && inc) m_hour = (m_hour + 1) % 24;
      m_up_prev   = up;
      m_down_prev = dn;
    end
    expq.push_back(disp_word(m_hour, m12));
    @(posedge clk);
    #1;
    compare("step", expq.pop_front());
  endtask

  task automatic do_reset(input logic m12);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, m12);
  endtask

  task automatic up_pulse(input logic m12);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, m12);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, m12);
  endtask

  initial begin
    bus.maqh_enable      = 1'b0;
    bus.maqh_incremento  = 1'b0;
    bus.maqh_ajuste_up   = 1'b0;
    bus.maqh_ajuste_down = 1'b0;
    bus.maqh_modo12      = 1'b0;

    // Reset held with incremento and up asserted; the held button fires once afterwards.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    compare("reset_24h", {2'd0, 4'd0, 1'b0, 1'b0});
    bus.maqh_modo12 = 1'b1;
    #1;
    compare("reset_12h", {2'd1, 4'd2, 1'b0, 1'b0});
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    compare("post_reset_edge", {2'd0, 4'd1, 1'b0, 1'b0});
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    compare("held_no_repeat", {2'd0, 4'd1, 1'b0, 1'b0});

    // Increment chain of 25 single-cycle pulses from 00.
    do_reset(1'b0);
    for (int i = 1; i <= 25; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      if (i == 10) compare("chain_10", {2'd1, 4'd0, 1'b0, 1'b0});
      if (i == 23) compare("chain_23", {2'd2, 4'd3, 1'b0, 1'b1});
      if (i == 24) compare("chain_wrap", {2'd0, 4'd0, 1'b0, 1'b0});
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    compare("chain_end", {2'd0, 4'd1, 1'b0, 1'b0});

    // Enable gating at 05: carries ignored, adjust still honoured.
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) up_pulse(1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    compare("gated_05", {2'd0, 4'd5, 1'b0, 1'b0});
    up_pulse(1'b0);
    compare("gated_up_06", {2'd0, 4'd6, 1'b0, 1'b0});

    // Adjust wrap both ways, and a long hold giving a single step.
    do_reset(1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    compare("down_wrap_23", {2'd2, 4'd3, 1'b0, 1'b1});
    up_pulse(1'b0);
    compare("up_wrap_00", {2'd0, 4'd0, 1'b0, 1'b0});
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    compare("hold_one_step", {2'd0, 4'd1, 1'b0, 1'b0});

    // Collisions at 10.
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) up_pulse(1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    compare("up_beats_inc", {2'd1, 4'd1, 1'b0, 1'b0});
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    compare("up_down_cancel", {2'd1, 4'd1, 1'b0, 1'b0});

    // 12h sweep with a mode toggle part way through.
    do_reset(1'b1);
    compare("h12_00", {2'd1, 4'd2, 1'b0, 1'b0});
    for (int h = 1; h <= 23; h++) begin
      up_pulse(1'b1);
      if (h == 11) compare("h12_11", {2'd1, 4'd1, 1'b0, 1'b0});
      if (h == 12) compare("h12_12", {2'd1, 4'd2, 1'b1, 1'b0});
      if (h == 13) compare("h12_13", {2'd0, 4'd1, 1'b1, 1'b0});
      if (h == 15) begin
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        compare("toggle_24h_15", {2'd1, 4'd5, 1'b0, 1'b0});
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        compare("toggle_back_03", {2'd0, 4'd3, 1'b1, 1'b0});
      end
    end
    compare("h12_23", {2'd1, 4'd1, 1'b1, 1'b1});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/maq_h.md
Name: maq_h

Overview:
- Hours stage of the digital clock. Sits downstream of the minutes stage and consumes its carry-to-hours output.
- Holds hour-of-day 00..23 internally, advances one hour per accepted increment, and supports manual up/down adjustment from push-buttons with internal edge detection.
- Presents BCD digits in 24h or 12h format with a PM flag, plus a day-carry level for a future date stage.

Parameters:
- RESET_HOUR, 0, internal hour (0..23) loaded on reset.

Ports:
- maqh_clock  input  1  system clock, all state updates on rising edge.
- maqh_reset  input  1  synchronous, active-low reset; sampled on rising edge of maqh_clock.
- maqh_enable  input  1  run enable; increment path ignored when low.
- maqh_incremento  input  1  carry from minutes stage, driven by its maqm_incrementahora.
- maqh_ajuste_up  input  1  raw button level, +1 hour on rising edge.
- maqh_ajuste_down  input  1  raw button level, -1 hour on rising edge.
- maqh_modo12  input  1  display format: 0 = 24h, 1 = 12h.
- maqh_Lsd  output  4  BCD units digit of displayed hour.
- maqh_Msd  output  2  BCD tens digit of displayed hour.
- maqh_pm  output  1  PM indicator (12h mode only).
- maqh_incrementadia  output  1  day-carry level.

Behaviour:
- State:
  - hora_reg, 5-bit binary, range 0..23.
  - up_prev, down_prev: 1-bit registered copies of the button inputs.
- Reset (maqh_reset == 0 at a clock edge):
  - hora_reg <= RESET_HOUR; up_prev <= 0; down_prev <= 0.
  - Reset overrides all other inputs in that cycle.
  - Reset mid-adjust: edge history is cleared, so a button held through reset release produces one edge on the first cycle after reset.
- Edge detect:
  - up_edge = maqh_ajuste_up & ~up_prev; down_edge = maqh_ajuste_down & ~down_prev.
  - up_prev and down_prev update every non-reset cycle.
- Next-state priority, highest first:
  1. up_edge && down_edge: no change; the increment in that cycle is also dropped.
  2. up_edge: hora = (hora == 23) ? 0 : hora + 1.
  3. down_edge: hora = (hora == 0) ? 23 : hora - 1.
  4. maqh_enable && maqh_incremento: hora = (hora == 23) ? 0 : hora + 1.
  5. Otherwise: hold.
- Adjust and enable:
  - Adjust is honoured regardless of maqh_enable.
  - Adjust in the same cycle as incremento: adjust wins, the increment is lost, no queueing.
- Increment semantics:
  - One hour per clock edge while maqh_enable && maqh_incremento are both high.
  - No internal pulse shaping; the upstream stage guarantees single-cycle qualification.
- Latency: outputs reflect a change one cycle after the causing edge; outputs are combinational from registered state and maqh_modo12.
- Display mapping, 24h (modo12 == 0):
  - digits = BCD(hora); Msd 0..2, Lsd 0..9; maqh_pm = 0.
- Display mapping, 12h (modo12 == 1):
  - hora 0 -> 12, maqh_pm = 0.
  - 1..11 -> same value, maqh_pm = 0.
  - 12 -> 12, maqh_pm = 1.
  - 13..23 -> hora - 12, maqh_pm = 1.
  - Msd is 0 or 1.
- Mode switching: changing maqh_modo12 alters only the display mapping, never hora_reg; takes effect the same cycle (combinational).
- Day carry:
  - maqh_incrementadia = (hora_reg == 23), a level, independent of display mode.
  - Consumer qualifies it with maqh_incremento, matching the minutes-to-hours chain convention.
- Reset outputs (RESET_HOUR = 0):
  - 24h mode: Msd = 0, Lsd = 0, pm = 0, incrementadia = 0.
  - 12h mode: digits show 12, pm = 0.
- Illegal state: hora_reg values 24..31 are unreachable; if ever present, the next increment or up-adjust loads 0 and a down-adjust loads 23.

Test Plan:
- Reset: hold reset low 3 cycles with incremento = 1 and up = 1, then release -> hora 00, Msd = 0, Lsd = 0, pm = 0; one up edge fires on the first post-reset cycle -> 01.
- Increment chain: enable = 1, 25 single-cycle incremento pulses from 00 -> passes 09 -> 10 (Msd = 1, Lsd = 0); incrementadia high only while 23; wraps to 00 and stops at 01.
- Enable gating: enable = 0 with 5 incremento pulses -> hour unchanged; an up edge still advances 05 -> 06.
- Adjust wrap: at 00, down edge -> 23 with incrementadia = 1; up edge -> 00. Button held 10 cycles -> exactly one step.
- Collisions: up edge coincident with incremento at 10 -> 11, not 12; up and down edges together at 10 -> 10.
- 12h mapping: sweep 00..23 with modo12 = 1 -> 00 shows 12/pm = 0, 11 shows 11/pm = 0, 12 shows 12/pm = 1, 13 shows 01/pm = 1, 23 shows 11/pm = 1. Toggle modo12 mid-sweep -> hora_reg unaffected.
